// File: rtl/clm_subbytes_sched.sv
// clm_subbytes_sched
// Serial SubBytes sequencer for a redundantly encoded AES state. One masked
// S-box is shared across all NBYTES elements: for each element the sequencer
// fetches a fresh randomness bundle, strobes the S-box, and waits for its
// result strobe. It then writes the result into the matching state_out element.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, abort     run control pulses (start wins over abort in IDLE)
//   state_in         input state, element k at [k*W +: W], snapshotted on start
//   state_out        substituted state, elements update as they are captured
//   busy, done       run in progress / one-cycle completion pulse
//   rnd_ready/valid  randomness handshake, rnd_in element j at [j*W +: W]
//   sb_in, sb_r      S-box data and randomness, held for the whole evaluation
//   sb_drdy_i/o      S-box start strobe / result-valid strobe
//   sb_out           S-box result
module clm_subbytes_sched #(
  parameter int d      = 4,
  parameter int NBYTES = 16,
  parameter int NR     = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NBYTES*(8+d)-1:0]  state_in,
  output logic [NBYTES*(8+d)-1:0]  state_out,
  output logic                     busy,
  output logic                     done,
  output logic                     rnd_ready,
  input  logic                     rnd_valid,
  input  logic [NR*(8+d)-1:0]      rnd_in,
  output logic [(8+d)-1:0]         sb_in,
  output logic [NR*(8+d)-1:0]      sb_r,
  output logic                     sb_drdy_i,
  input  logic                     sb_drdy_o,
  input  logic [(8+d)-1:0]         sb_out
);

  localparam int W  = 8 + d;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         w_idx_nxt;
  logic [NBYTES*W-1:0]   r_snap;
  logic [NBYTES*W-1:0]   r_state_out;
  logic [NR*W-1:0]       r_sb_r;
  logic                  w_snap_we;
  logic                  w_rnd_we;
  logic                  w_out_we;

  // ---------------------------------------------------------------------------
  // Next-state logic. abort is checked before every other transition in the
  // states where it applies; once the S-box has been strobed it cannot be
  // stopped, so an abort there drains the pending result instead.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_snap_we   = 1'b0;
    w_rnd_we    = 1'b0;
    w_out_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_snap_we   = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (rnd_valid) begin
          w_rnd_we    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = abort ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          // A result arriving in the abort cycle is simply dropped.
          w_state_nxt = sb_drdy_o ? S_IDLE : S_DRAIN;
        end else if (sb_drdy_o) begin
          w_out_we = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (sb_drdy_o) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, index, snapshot, randomness and result registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap <= '0;
    end else if (w_snap_we) begin
      r_snap <= state_in;
    end
  end

  // sb_r only changes in FETCH, so it is stable while the S-box is evaluating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_r <= '0;
    end else if (w_rnd_we) begin
      r_sb_r <= rnd_in;
    end
  end

  // Only the element being processed is written; the others keep old values,
  // including results from earlier runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_out <= '0;
    end else if (w_out_we) begin
      r_state_out[r_idx*W +: W] <= sb_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are decoded from registers only.
  // ---------------------------------------------------------------------------
  assign sb_in     = r_snap[r_idx*W +: W];
  assign sb_r      = r_sb_r;
  assign state_out = r_state_out;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign rnd_ready = (r_state == S_FETCH);
  assign sb_drdy_i = (r_state == S_ISSUE);

endmodule

// File: tb/tb_clm_subbytes_sched.sv
// Bench for clm_subbytes_sched: a behavioural masked S-box, randomized state
// and randomness, and directed control scenarios.
module tb_clm_subbytes_sched;

  localparam int D  = 4;
  localparam int NB = 16;
  localparam int NR = 7;
  localparam int W  = 8 + D;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [NB*W-1:0]   state_in;
  logic [NB*W-1:0]   state_out;
  logic              busy;
  logic              done;
  logic              rnd_ready;
  logic              rnd_valid;
  logic [NR*W-1:0]   rnd_in;
  logic [W-1:0]      sb_in;
  logic [NR*W-1:0]   sb_r;
  logic              sb_drdy_i;
  logic              sb_drdy_o;
  logic [W-1:0]      sb_out;

  clm_subbytes_sched #(.d(D), .NBYTES(NB), .NR(NR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .state_in(state_in), .state_out(state_out), .busy(busy), .done(done),
    .rnd_ready(rnd_ready), .rnd_valid(rnd_valid), .rnd_in(rnd_in),
    .sb_in(sb_in), .sb_r(sb_r), .sb_drdy_i(sb_drdy_i),
    .sb_drdy_o(sb_drdy_o), .sb_out(sb_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    if (b != 8'h00) begin
      for (int x = 1; x < 256; x++) begin
        if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // Redundant encoding: byte plus a multiple of the AES polynomial.
  function automatic logic [W-1:0] encode(input logic [7:0] b, input logic [D-1:0] m);
    logic [W-1:0] e;
    e = {{D{1'b0}}, b};
    for (int i = 0; i < D; i++) begin
      if (m[i]) e = e ^ (12'h11B << i);
    end
    return e;
  endfunction

  function automatic logic [7:0] decode(input logic [W-1:0] e);
    logic [W-1:0] t;
    t = e;
    for (int i = W - 1; i >= 8; i--) begin
      if (t[i]) t = t ^ (12'h11B << (i - 8));
    end
    return t[7:0];
  endfunction

  // ---------------- behavioural masked S-box (6-cycle latency) ----------------
  logic [W-1:0]    m_in;
  logic [NR*W-1:0] m_r;
  logic            m_act;
  int              m_cnt;
  int              model_errs = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_cnt <= 0;
    end else begin
      if (m_act) begin
        assert ({sb_in, sb_r} === {m_in, m_r}) else begin
          $error("FAIL sb_hold observed=%0h/%0h expected=%0h/%0h", sb_in, sb_r, m_in, m_r);
          model_errs <= model_errs + 1;
        end
        if (m_cnt == 0) m_act <= 1'b0;
        else            m_cnt <= m_cnt - 1;
      end
      if (sb_drdy_i) begin
        m_act <= 1'b1;
        m_cnt <= 5;
        m_in  <= sb_in;
        m_r   <= sb_r;
      end
    end
  end

  assign sb_drdy_o = m_act && (m_cnt == 0);
  assign sb_out    = encode(aes_sbox(decode(m_in)), m_r[D-1:0]);

  // ---------------- monitors ----------------
  logic [NR*W-1:0] bun_q[$];
  int              stb_t[$];
  int              done_t[$];

  always @(posedge clk) begin
    if (rst_n && rnd_ready && rnd_valid && !abort) bun_q.push_back(rnd_in);
  end

  always @(negedge clk) begin
    if (sb_drdy_i) stb_t.push_back(cyc);
    if (done) done_t.push_back(cyc);
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_out [NB];
  logic [7:0]   bytes   [NB];

  task automatic chk_v(input string tag, input logic [NB*W-1:0] obs, input logic [NB*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [95:0] r;
    @(negedge clk);
    r = {$urandom, $urandom, $urandom};
    rnd_in = r[NR*W-1:0];
  endtask

  task automatic pulse_start(output int t0);
    tick();
    start = 1'b1;
    t0    = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int t0, output int lat);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    lat = (n < 400) ? (cyc - t0) : -1;
  endtask

  task automatic load_state(input logic rand_bytes);
    for (int k = 0; k < NB; k++) begin
      bytes[k] = rand_bytes ? 8'($urandom) : 8'(k);
      state_in[k*W +: W] = encode(bytes[k], D'($urandom));
    end
  endtask

  task automatic update_exp(input int bq0, input int n);
    for (int k = 0; k < n; k++) begin
      exp_out[k] = encode(aes_sbox(bytes[k]), bun_q[bq0 + k][D-1:0]);
    end
  endtask

  function automatic logic [NB*W-1:0] exp_vec();
    logic [NB*W-1:0] v;
    for (int k = 0; k < NB; k++) v[k*W +: W] = exp_out[k];
    return v;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int t0, lat, bq0, s0, d0, bad;
    logic [NR*W-1:0] sbr_prev;
    logic [NB*W-1:0] out_prev;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rnd_valid = 1'b0;
    state_in = '0; rnd_in = '0;
    for (int k = 0; k < NB; k++) exp_out[k] = '0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk_b("idle_busy", busy, 1'b0);
    chk_b("idle_rnd_ready", rnd_ready, 1'b0);
    chk_b("idle_done", done, 1'b0);
    chk_v("idle_state_out", state_out, '0);

    // Full run, bytes 0x00..0x0F, randomness always available.
    load_state(1'b0);
    rnd_valid = 1'b1;
    bq0 = bun_q.size(); s0 = stb_t.size(); d0 = done_t.size();
    pulse_start(t0);
    wait_done(t0, lat);
    chk_i("run1_latency", lat, 129);
    tick();
    chk_b("run1_done_pulse", done, 1'b0);
    chk_b("run1_busy_after", busy, 1'b0);
    update_exp(bq0, NB);
    chk_v("run1_state_out", state_out, exp_vec());
    chk_i("run1_s00", int'(decode(state_out[W-1:0])), 'h63);
    chk_i("run1_s01", int'(decode(state_out[2*W-1:W])), 'h7C);
    chk_i("run1_strobes", stb_t.size() - s0, NB);
    bad = 0;
    for (int i = s0 + 1; i < stb_t.size(); i++) if (stb_t[i] - stb_t[i-1] != 8) bad++;
    chk_i("run1_strobe_gap", bad, 0);
    if (stb_t.size() > s0) chk_i("run1_first_strobe", stb_t[s0] - t0, 2);
    chk_i("run1_bundles", bun_q.size() - bq0, NB);
    chk_i("run1_dones", done_t.size() - d0, 1);

    // Backpressure: randomness withheld for 5 cycles at byte 3's fetch.
    load_state(1'b1);
    bq0 = bun_q.size(); s0 = stb_t.size();
    pulse_start(t0);
    while (cyc < t0 + 25) tick();
    rnd_valid = 1'b0;
    repeat (5) tick();
    rnd_valid = 1'b1;
    wait_done(t0, lat);
    chk_i("run2_latency", lat, 134);
    update_exp(bq0, NB);
    chk_v("run2_state_out", state_out, exp_vec());
    if (stb_t.size() >= s0 + 4) chk_i("run2_gap_byte3", stb_t[s0+3] - stb_t[s0+2], 13);
    tick();

    // Abort in WAIT of byte 5: drain, no done, elements 5..15 untouched.
    load_state(1'b1);
    bq0 = bun_q.size(); d0 = done_t.size();
    pulse_start(t0);
    while (cyc < t0 + 45) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_b("abort_wait_busy_drain", busy, 1'b1);
    while (cyc < t0 + 48) tick();
    chk_b("abort_wait_busy_last", busy, 1'b1);
    tick();
    chk_b("abort_wait_idle", busy, 1'b0);
    repeat (5) tick();
    chk_i("abort_wait_no_done", done_t.size() - d0, 0);
    chk_i("abort_wait_bundles", bun_q.size() - bq0, 6);
    update_exp(bq0, 5);
    chk_v("abort_wait_state_out", state_out, exp_vec());

    // Abort in FETCH while randomness is offered.
    sbr_prev = sb_r; out_prev = state_out;
    s0 = stb_t.size(); d0 = done_t.size();
    pulse_start(t0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_b("abort_fetch_busy", busy, 1'b0);
    chk_b("abort_fetch_rnd_ready", rnd_ready, 1'b0);
    repeat (10) tick();
    chk_v("abort_fetch_sb_r", (NB*W)'(sb_r), (NB*W)'(sbr_prev));
    chk_i("abort_fetch_strobes", stb_t.size() - s0, 0);
    chk_i("abort_fetch_dones", done_t.size() - d0, 0);
    chk_v("abort_fetch_state_out", state_out, out_prev);

    // start during a run and during DONE is ignored; state_in changes late.
    load_state(1'b1);
    bq0 = bun_q.size(); d0 = done_t.size();
    pulse_start(t0);
    repeat (3) tick();
    for (int k = 0; k < NB; k++) state_in[k*W +: W] = W'($urandom);
    while (cyc < t0 + 50) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < t0 + 129 && done !== 1'b1) tick();
    chk_b("ign_done_cycle", done, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_b("ign_done_low", done, 1'b0);
    chk_b("ign_busy_after_done", busy, 1'b0);
    tick();
    chk_b("ign_start_in_done", busy, 1'b0);
    repeat (5) tick();
    chk_i("ign_one_done", done_t.size() - d0, 1);
    update_exp(bq0, NB);
    chk_v("ign_state_out", state_out, exp_vec());

    // Asynchronous reset in the middle of a run.
    load_state(1'b1);
    pulse_start(t0);
    while (cyc < t0 + 20) tick();
    #2 rst_n = 1'b0;
    #1;
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_rnd_ready", rnd_ready, 1'b0);
    chk_b("rst_sb_drdy_i", sb_drdy_i, 1'b0);
    chk_v("rst_state_out", state_out, '0);
    chk_v("rst_sb_r", (NB*W)'(sb_r), '0);
    chk_v("rst_sb_in", (NB*W)'(sb_in), '0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk_b("rst_stays_idle", busy, 1'b0);

    chk_i("sbox_input_stability", model_errs, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
